// File: rtl/bus_pkg.sv
// Shared bus constants and word/id types used by the per-PE receive stage.
package bus_pkg;

  localparam int NUM_PE       = 8;
  localparam int DATA_LEN     = 16;
  localparam int BUS_ADDR_LEN = 3;

  typedef logic [BUS_ADDR_LEN-1:0] pe_id_t;
  typedef logic [DATA_LEN-1:0]     bus_word_t;

endpackage

// File: rtl/bus_rd_buffer_if.sv
// Bus-side and PE-side signals of one bus_rd_buffer; master = bus master/PE side, slave = buffer.
interface bus_rd_buffer_if;
  import bus_pkg::*;

  bus_word_t bus_data;
  pe_id_t    addr_bus;
  logic      rd_from_bus;
  pe_id_t    src_addr;
  logic      src_rq;
  bus_word_t src_data;
  logic      src_valid;
  logic      rd_buffer_full;
  logic      rd_overflow;

  modport master (
    output bus_data, addr_bus, rd_from_bus, src_addr, src_rq,
    input  src_data, src_valid, rd_buffer_full, rd_overflow
  );

  modport slave (
    input  bus_data, addr_bus, rd_from_bus, src_addr, src_rq,
    output src_data, src_valid, rd_buffer_full, rd_overflow
  );

endinterface

// File: rtl/bus_rd_buffer_rd_slot_fifo.sv
// One source slot: small circular FIFO with combinational head. The caller never pushes
// a full slot unless it pops in the same cycle.
module rd_slot_fifo
  import bus_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  bus_word_t        din,
  output bus_word_t        dout,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  bus_word_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  assign dout  = mem[rd_ptr_reg];
  assign empty = (count_reg == '0);
  assign full  = (count_reg == CNT_W'(DEPTH));
  assign count = count_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // DEPTH is a power of two, so pointer wrap is the natural overflow of PTR_W bits
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      if (push && !pop) begin
        count_reg <= count_reg + CNT_W'(1);
      end else if (pop && !push) begin
        count_reg <= count_reg - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/bus_rd_buffer.sv
// Per-PE receive stage: sorts bus words into per-source FIFOs and serves reads by source id.
// Optional macro RD_BUF_BYPASS_EN: a read of an empty slot hits on a same-cycle push to it.
module bus_rd_buffer
  import bus_pkg::*;
#(
  parameter int SLOT_DEPTH = 2
) (
  input  logic           clk,
  input  logic           rstn,
  bus_rd_buffer_if.slave bus
);

  localparam int TOTAL = NUM_PE * SLOT_DEPTH;
  localparam int OCC_W = $clog2(TOTAL + 1);
  localparam int CNT_W = $clog2(SLOT_DEPTH + 1);

  bus_word_t         dout_arr  [NUM_PE];
  logic [CNT_W-1:0]  count_arr [NUM_PE];
  logic [NUM_PE-1:0] empty_vec;
  logic [NUM_PE-1:0] full_vec;
  logic [NUM_PE-1:0] push_vec;
  logic [NUM_PE-1:0] pop_vec;

  logic             wr_ok;
  logic             rd_ok;
  logic             same_slot;
  logic             pop_hit;
  logic             push_accept;
  logic             bypass;
  logic             fifo_push;
  logic [OCC_W-1:0] occ_reg;
  logic [OCC_W-1:0] occ_next;

  logic      src_valid_reg;
  bus_word_t src_data_reg;
  logic      full_reg;
  logic      overflow_reg;

  always_comb begin
    wr_ok     = bus.rd_from_bus && (int'(bus.addr_bus) < NUM_PE);
    rd_ok     = bus.src_rq && (int'(bus.src_addr) < NUM_PE);
    same_slot = (bus.src_addr == bus.addr_bus);
    pop_hit   = rd_ok && !empty_vec[bus.src_addr];
    // a pop from the same full slot frees the entry the push lands in
    push_accept = wr_ok && (!full_vec[bus.addr_bus] || (pop_hit && same_slot));
`ifdef RD_BUF_BYPASS_EN
    bypass = push_accept && rd_ok && same_slot && (count_arr[bus.addr_bus] == '0);
`else
    bypass = 1'b0;
`endif
    fifo_push = push_accept && !bypass;

    occ_next = occ_reg;
    if (fifo_push && !pop_hit) begin
      occ_next = occ_reg + OCC_W'(1);
    end else if (pop_hit && !fifo_push) begin
      occ_next = occ_reg - OCC_W'(1);
    end
  end

  for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_slot
    assign push_vec[gi] = fifo_push && (bus.addr_bus == pe_id_t'(gi));
    assign pop_vec[gi]  = pop_hit && (bus.src_addr == pe_id_t'(gi));

    rd_slot_fifo #(
      .DEPTH (SLOT_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (push_vec[gi]),
      .pop   (pop_vec[gi]),
      .din   (bus.bus_data),
      .dout  (dout_arr[gi]),
      .empty (empty_vec[gi]),
      .full  (full_vec[gi]),
      .count (count_arr[gi])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      src_valid_reg <= 1'b0;
      src_data_reg  <= '0;
      occ_reg       <= '0;
      full_reg      <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      src_valid_reg <= pop_hit || bypass;
      if (pop_hit) begin
        src_data_reg <= dout_arr[bus.src_addr];
      end else if (bypass) begin
        src_data_reg <= bus.bus_data;
      end
      occ_reg  <= occ_next;
      // one-entry margin absorbs the master's grant latency
      full_reg <= (occ_next >= OCC_W'(TOTAL - 1));
      if (bus.rd_from_bus && !push_accept) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  assign bus.src_valid      = src_valid_reg;
  assign bus.src_data       = src_data_reg;
  assign bus.rd_buffer_full = full_reg;
  assign bus.rd_overflow    = overflow_reg;

endmodule

// File: tb/tb_bus_rd_buffer.sv
// Directed plan steps plus random traffic, checked against a queue-per-source reference model.
module tb_bus_rd_buffer;
  import bus_pkg::*;

  localparam int SLOT_DEPTH = 2;
  localparam int TOTAL      = NUM_PE * SLOT_DEPTH;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  bus_rd_buffer_if bus ();

  bus_rd_buffer #(
    .SLOT_DEPTH (SLOT_DEPTH)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  bus_word_t mq [NUM_PE][$];
  logic      exp_valid;
  bus_word_t exp_data;
  logic      exp_full;
  logic      exp_ovf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_valid"}, 32'(bus.src_valid), 32'(exp_valid));
    chk({tag, "_data"}, 32'(bus.src_data), 32'(exp_data));
    chk({tag, "_full"}, 32'(bus.rd_buffer_full), 32'(exp_full));
    chk({tag, "_ovf"}, 32'(bus.rd_overflow), 32'(exp_ovf));
  endtask

  task automatic model_clear();
    for (int i = 0; i < NUM_PE; i++) mq[i].delete();
    exp_valid = 1'b0;
    exp_data  = '0;
    exp_full  = 1'b0;
    exp_ovf   = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.rd_from_bus = 1'b0;
    bus.src_rq      = 1'b0;
    bus.addr_bus    = '0;
    bus.src_addr    = '0;
    bus.bus_data    = '0;
  endtask

  // One clock of traffic; the model applies the behavioural rules to its pre-edge queue state.
  task automatic cycle(input string tag, input logic rd, input pe_id_t a, input bus_word_t d,
                       input logic rq, input pe_id_t sa);
    logic hit;
    logic acc;
    logic byp;
    int   occ;
    bus.rd_from_bus = rd;
    bus.addr_bus    = a;
    bus.bus_data    = d;
    bus.src_rq      = rq;
    bus.src_addr    = sa;
    @(posedge clk);
    hit = rq && (mq[sa].size() > 0);
    acc = 1'b0;
    byp = 1'b0;
    if (rd) begin
      if (mq[a].size() < SLOT_DEPTH || (hit && sa == a)) acc = 1'b1;
      else exp_ovf = 1'b1;
    end
`ifdef RD_BUF_BYPASS_EN
    byp = acc && rq && (sa == a) && (mq[a].size() == 0);
`endif
    if (hit) exp_data = mq[sa].pop_front();
    else if (byp) exp_data = d;
    exp_valid = hit || byp;
    if (acc && !byp) mq[a].push_back(d);
    occ = 0;
    for (int i = 0; i < NUM_PE; i++) occ += mq[i].size();
    exp_full = (occ >= TOTAL - 1);
    #1;
    chk_all(tag);
    $display("cyc %s rd=%0b a=%0d d=%04h rq=%0b sa=%0d -> valid=%0b data=%04h full=%0b ovf=%0b",
             tag, rd, a, d, rq, sa, bus.src_valid, bus.src_data, bus.rd_buffer_full,
             bus.rd_overflow);
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear without a clock.
  task automatic do_reset(input string tag);
    #3;
    rstn = 1'b0;
    idle_inputs();
    #1;
    model_clear();
    chk_all(tag);
    $display("reset %s valid=%0b data=%04h full=%0b ovf=%0b", tag, bus.src_valid,
             bus.src_data, bus.rd_buffer_full, bus.rd_overflow);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    pe_id_t    ra;
    pe_id_t    rs;
    checks = 0;
    errors = 0;
    rstn   = 1'b0;
    idle_inputs();
    model_clear();
    #12;
    chk_all("por");
    @(negedge clk);
    rstn = 1'b1;

    // 1: single push/read, then a miss
    cycle("t1_push", 1'b1, 3'd3, 16'h1103, 1'b0, 3'd0);
    cycle("t1_rd", 1'b0, 3'd0, 16'h0, 1'b1, 3'd3);
    chk("t1_const_valid", 32'(bus.src_valid), 32'd1);
    chk("t1_const_data", 32'(bus.src_data), 32'h1103);
    cycle("t1_miss", 1'b0, 3'd0, 16'h0, 1'b1, 3'd3);
    chk("t1_const_miss", 32'(bus.src_valid), 32'd0);

    // 2: overflow on a full slot
    cycle("t2_p0", 1'b1, 3'd5, 16'hA000, 1'b0, 3'd0);
    cycle("t2_p1", 1'b1, 3'd5, 16'hA001, 1'b0, 3'd0);
    cycle("t2_p2", 1'b1, 3'd5, 16'hA002, 1'b0, 3'd0);
    chk("t2_const_ovf", 32'(bus.rd_overflow), 32'd1);
    cycle("t2_r0", 1'b0, 3'd0, 16'h0, 1'b1, 3'd5);
    chk("t2_const_r0", 32'(bus.src_data), 32'hA000);
    cycle("t2_r1", 1'b0, 3'd0, 16'h0, 1'b1, 3'd5);
    chk("t2_const_r1", 32'(bus.src_data), 32'hA001);
    cycle("t2_r2", 1'b0, 3'd0, 16'h0, 1'b1, 3'd5);
    chk("t2_const_r2", 32'(bus.src_valid), 32'd0);

    // 3: rd_buffer_full threshold at 15 of 16 entries
    do_reset("t3_rst");
    for (int i = 0; i < 7; i++) cycle("t3_one", 1'b1, pe_id_t'(i), 16'h3000 + 16'(i), 1'b0, 3'd0);
    chk("t3_const_notfull", 32'(bus.rd_buffer_full), 32'd0);
    for (int i = 0; i < 7; i++) cycle("t3_two", 1'b1, pe_id_t'(i), 16'h3100 + 16'(i), 1'b0, 3'd0);
    chk("t3_const_14", 32'(bus.rd_buffer_full), 32'd0);
    cycle("t3_15", 1'b1, 3'd7, 16'h3107, 1'b0, 3'd0);
    chk("t3_const_full", 32'(bus.rd_buffer_full), 32'd1);
    cycle("t3_rd", 1'b0, 3'd0, 16'h0, 1'b1, 3'd0);
    chk("t3_const_drop", 32'(bus.rd_buffer_full), 32'd0);

    // 4: push into a full slot while popping it
    do_reset("t4_rst");
    cycle("t4_p0", 1'b1, 3'd2, 16'hB000, 1'b0, 3'd0);
    cycle("t4_p1", 1'b1, 3'd2, 16'hB001, 1'b0, 3'd0);
    cycle("t4_pp", 1'b1, 3'd2, 16'hB002, 1'b1, 3'd2);
    chk("t4_const_data", 32'(bus.src_data), 32'hB000);
    chk("t4_const_ovf", 32'(bus.rd_overflow), 32'd0);
    cycle("t4_r1", 1'b0, 3'd0, 16'h0, 1'b1, 3'd2);
    chk("t4_const_r1", 32'(bus.src_data), 32'hB001);
    cycle("t4_r2", 1'b0, 3'd0, 16'h0, 1'b1, 3'd2);
    chk("t4_const_r2", 32'(bus.src_data), 32'hB002);

    // 5: push into an empty slot while reading it
    cycle("t5_pr", 1'b1, 3'd4, 16'hC004, 1'b1, 3'd4);
`ifdef RD_BUF_BYPASS_EN
    chk("t5_const_byp", 32'(bus.src_valid), 32'd1);
    chk("t5_const_bypd", 32'(bus.src_data), 32'hC004);
    cycle("t5_next", 1'b0, 3'd0, 16'h0, 1'b1, 3'd4);
    chk("t5_const_miss", 32'(bus.src_valid), 32'd0);
`else
    chk("t5_const_nobyp", 32'(bus.src_valid), 32'd0);
    cycle("t5_next", 1'b0, 3'd0, 16'h0, 1'b1, 3'd4);
    chk("t5_const_hit", 32'(bus.src_data), 32'hC004);
`endif

    // random traffic, with a mid-stream reset partway through
    for (int n = 0; n < 600; n++) begin
      ra = pe_id_t'($urandom_range(0, NUM_PE - 1));
      rs = ($urandom_range(0, 3) == 0) ? ra : pe_id_t'($urandom_range(0, NUM_PE - 1));
      cycle("rnd", ($urandom_range(0, 9) < 6), ra, bus_word_t'($urandom), ($urandom_range(0, 1) == 1), rs);
      if (n == 300) begin
        // 6: reset with stored data, then the first read misses
        do_reset("t6_rst");
        cycle("t6_miss", 1'b0, 3'd0, 16'h0, 1'b1, rs);
        chk("t6_const_miss", 32'(bus.src_valid), 32'd0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
